chip_74161_model: RTL
=====================

// Module: chip_74161_model
// PURPOSE
//  Cycle-accurate behavioural model of a 74161 synchronous 4-bit binary counter.
//  It is the chip side of the tester pin interface: it answers the chip-tester
//  FSM the way a good part would, so tester FSMs can be verified without silicon.
//  It samples the tester-driven pins (CLR_n, LOAD_n, ENP, ENT, CLK, D[3:0]) in
//  the board Clk domain and drives Q[3:0] and RCO back.
// PARAMETERS
//  SYNC_STAGES  2  flops per input-pin synchroniser (>=2)
//  PROP_DELAY   0  extra Clk stages on {q,rco} to emulate propagation delay (0..7)
//  EDGE_CNT_W   8  width of the saturating chip-clock edge counter
// PORTS
//  Clk        in   1  board clock
//  Reset      in   1  synchronous, active-low reset
//  pin_clr_n  in   1  chip CLR_n (active-low clear)
//  pin_ld_n   in   1  chip LOAD_n (active-low parallel load)
//  pin_enp    in   1  chip ENP
//  pin_ent    in   1  chip ENT
//  pin_clk    in   1  chip CLK, driven by the tester, asynchronous to Clk
//  pin_d      in   4  chip D[3:0]
//  pin_q      out  4  chip Q[3:0]
//  pin_rco    out  1  chip RCO
//  edge_cnt   out  EDGE_CNT_W  count of pin_clk rising edges detected, saturating
// BEHAVIOUR
//  - One clock, Clk. Reset is synchronous and active-low: Reset==0 at a Clk edge
//    does the following:
//    - count=0, pin_q=0, pin_rco=0, edge_cnt=0.
//    - Clears all sync and delay stages.
//    - Loads arm_cnt=SYNC_STAGES+1.
//    Reset asserted mid-operation aborts everything the same way.
//  - Every pin passes through a SYNC_STAGES flop chain. Call the outputs s_*.
//    pin_d, ld_n, enp and ent use the same depth, so they stay aligned with s_clk.
//  - Edge detect: rise = s_clk & ~s_clk_q.
//    - While arm_cnt!=0, rise is ignored and arm_cnt decrements once per Clk.
//    - This stops a pin_clk held high through reset release from being counted.
//  - State update, per Clk, with priority in this order:
//    1. s_clr_n==0: count<=0. This is level-sensitive and needs no edge. It wins
//       over a same-cycle rise.
//    2. rise & s_ld_n==0: count<=s_d. Load wins over enables.
//    3. rise & s_enp & s_ent: count<=count+1, 4-bit, 15->0 wraps.
//    4. Otherwise count holds.
//  - Every accepted rise increments edge_cnt, saturating at all-ones. A rise
//    during clear is still counted.
//  - rco_int = s_ent & (count==4'hF). It is combinational from state.
//  - Output: {pin_q,pin_rco} = {count,rco_int} delayed by PROP_DELAY registers.
//    With PROP_DELAY=0 there are no extra stages.
//  - Latency from a pin_clk rise to pin_q change: SYNC_STAGES+1+PROP_DELAY Clk.
//    The sync chain takes SYNC_STAGES cycles and the count register takes 1.
//  - pin_clk pulses shorter than SYNC_STAGES Clk high/low are unsupported. The
//    tester guarantees >=4 Clk per phase.
// CONFIGURATION
//  - Macro CHIP_MODEL_FAULT_INJECT_EN adds three inputs:
//    - fault_en: 1 bit
//    - fault_bit: 2 bits
//    - fault_val: 1 bit
//  - When fault_en=1, pin_q[fault_bit] is forced to fault_val after the delay
//    pipe (stuck-at fault). This lets tester FAIL paths be checked.
//  - Without the macro these ports do not exist and pin_q is unmodified.
// STRUCTURE
//  - Package chip_model_pkg holds:
//    - typedef logic [3:0] nibble_t
//    - localparam nibble_t CNT_MAX = 4'hF
//    - typedef struct packed {clr_n, ld_n, enp, ent, clk; nibble_t d} pins_in_t
//  - Sub-module pin_sync: parameterised-width SYNC_STAGES synchroniser. One
//    instance is used, on the packed pins_in_t.
// TESTING
//  1. Reset=0 for 2 Clk while pin_clk=1, then release. Required:
//     - pin_q=0 and rco=0 throughout.
//     - No count occurs.
//     - edge_cnt stays 0.
//  2. clr_n=1, ld_n=1, enp=ent=1, 17 pin_clk pulses. Required:
//     - pin_q goes 1,2,...,15,0,1.
//     - rco=1 only while q=15.
//     - edge_cnt=17.
//  3. ld_n=0, d=4'hA, one pulse, then ld_n=1 with 5 enabled pulses. Required:
//     - q=A, then B, C, D, E, F.
//     - rco=1 at F.
//     - Dropping ent with q=F drives rco=0.
//  4. Set enp=0 with ent=1 and give 3 pulses: q holds. Then set q=F with ent=0:
//     rco=0.
//  5. clr_n=0 in the same Clk as a synced rise with ld_n=0, d=5. Required:
//     - q=0 (clear wins).
//     - edge_cnt increments.
//  6. With CHIP_MODEL_FAULT_INJECT_EN and PROP_DELAY=2: set fault_en=1,
//     fault_bit=2, fault_val=0, count to 7. Required:
//     - pin_q=3.
//     - A rise-to-Q latency of 5 Clk is observed.

Source files
------------

// File: rtl/chip_model_pkg.sv
// Shared types for the 74161 chip model: nibble type, counter limit and the
// packed bundle of tester-driven pins that goes through one synchroniser.
package chip_model_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t CNT_MAX = 4'hF;

  typedef struct packed {
    logic    clr_n;
    logic    ld_n;
    logic    enp;
    logic    ent;
    logic    clk;
    nibble_t d;
  } pins_in_t;

  localparam int PINS_W = $bits(pins_in_t);

  function automatic nibble_t cnt_inc(input nibble_t v);
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/chip_74161_model_if.sv
// Tester <-> chip pin bundle for the 74161 model. The stuck-at fault inputs
// exist only when CHIP_MODEL_FAULT_INJECT_EN is defined.
interface chip_74161_model_if
  import chip_model_pkg::*;
#(
  parameter int EDGE_CNT_W = 8
);

  logic                  pin_clr_n;
  logic                  pin_ld_n;
  logic                  pin_enp;
  logic                  pin_ent;
  logic                  pin_clk;
  nibble_t               pin_d;
  nibble_t               pin_q;
  logic                  pin_rco;
  logic [EDGE_CNT_W-1:0] edge_cnt;
`ifdef CHIP_MODEL_FAULT_INJECT_EN
  logic                  fault_en;
  logic [1:0]            fault_bit;
  logic                  fault_val;

  modport master (
    output pin_clr_n, pin_ld_n, pin_enp, pin_ent, pin_clk, pin_d,
    output fault_en, fault_bit, fault_val,
    input  pin_q, pin_rco, edge_cnt
  );

  modport slave (
    input  pin_clr_n, pin_ld_n, pin_enp, pin_ent, pin_clk, pin_d,
    input  fault_en, fault_bit, fault_val,
    output pin_q, pin_rco, edge_cnt
  );
`else
  modport master (
    output pin_clr_n, pin_ld_n, pin_enp, pin_ent, pin_clk, pin_d,
    input  pin_q, pin_rco, edge_cnt
  );

  modport slave (
    input  pin_clr_n, pin_ld_n, pin_enp, pin_ent, pin_clk, pin_d,
    output pin_q, pin_rco, edge_cnt
  );
`endif

endinterface

// File: rtl/chip_74161_model_pin_sync.sv
// Multi-stage flop synchroniser for a bundle of asynchronous pins; all bits
// share the same depth so they stay aligned with each other.
module pin_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/chip_74161_model.sv
// Cycle-accurate 74161 4-bit counter model answering a chip tester's pins.
// Optional stuck-at fault on pin_q via CHIP_MODEL_FAULT_INJECT_EN.
module chip_74161_model
  import chip_model_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PROP_DELAY  = 0,
  parameter int EDGE_CNT_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  chip_74161_model_if.slave  pins
);

  localparam int                    ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]      ARM_INIT = ARM_W'(SYNC_STAGES + 1);
  localparam logic [EDGE_CNT_W-1:0] EDGE_MAX = '1;

  pins_in_t raw_pins;
  pins_in_t s_pins;

  always_comb begin
    raw_pins.clr_n = pins.pin_clr_n;
    raw_pins.ld_n  = pins.pin_ld_n;
    raw_pins.enp   = pins.pin_enp;
    raw_pins.ent   = pins.pin_ent;
    raw_pins.clk   = pins.pin_clk;
    raw_pins.d     = pins.pin_d;
  end

  pin_sync #(
    .WIDTH  (PINS_W),
    .STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .din   (raw_pins),
    .dout  (s_pins)
  );

  logic                  s_clk_q,    s_clk_d;
  logic [ARM_W-1:0]      arm_cnt_q,  arm_cnt_d;
  nibble_t               count_q,    count_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  rise;
  logic                  rco_int;
  logic [4:0]            out_now;
  logic [4:0]            out_del;
  nibble_t               q_out;

  // Edges are ignored until the sync chain has refilled after reset, so a
  // pin_clk held high through reset release is not mistaken for a rise.
  always_comb begin
    s_clk_d   = s_pins.clk;
    arm_cnt_d = arm_cnt_q;
    if (arm_cnt_q != '0) begin
      arm_cnt_d = arm_cnt_q - ARM_W'(1);
    end
    rise = s_pins.clk & ~s_clk_q & (arm_cnt_q == '0);

    count_d = count_q;
    if (!s_pins.clr_n) begin
      count_d = '0;
    end else if (rise && !s_pins.ld_n) begin
      count_d = s_pins.d;
    end else if (rise && s_pins.enp && s_pins.ent) begin
      count_d = cnt_inc(count_q);
    end

    edge_cnt_d = edge_cnt_q;
    if (rise && (edge_cnt_q != EDGE_MAX)) begin
      edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s_clk_q    <= 1'b0;
      arm_cnt_q  <= ARM_INIT;
      count_q    <= '0;
      edge_cnt_q <= '0;
    end else begin
      s_clk_q    <= s_clk_d;
      arm_cnt_q  <= arm_cnt_d;
      count_q    <= count_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign rco_int = s_pins.ent & (count_q == CNT_MAX);
  assign out_now = {count_q, rco_int};

  generate
    if (PROP_DELAY == 0) begin : g_no_delay
      assign out_del = out_now;
    end else begin : g_delay
      logic [4:0] dly_q [PROP_DELAY];
      logic [4:0] dly_d [PROP_DELAY];

      always_comb begin
        dly_d[0] = out_now;
        for (int i = 1; i < PROP_DELAY; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end

      always_ff @(posedge Clk) begin
        if (!Reset) begin
          for (int i = 0; i < PROP_DELAY; i++) begin
            dly_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < PROP_DELAY; i++) begin
            dly_q[i] <= dly_d[i];
          end
        end
      end

      assign out_del = dly_q[PROP_DELAY-1];
    end
  endgenerate

`ifdef CHIP_MODEL_FAULT_INJECT_EN
  // Stuck-at is applied after the delay pipe so it acts like a damaged pin.
  always_comb begin
    q_out = out_del[4:1];
    if (pins.fault_en) begin
      q_out[pins.fault_bit] = pins.fault_val;
    end
  end
`else
  assign q_out = out_del[4:1];
`endif

  assign pins.pin_q    = q_out;
  assign pins.pin_rco  = out_del[0];
  assign pins.edge_cnt = edge_cnt_q;

endmodule
